// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser.
// 7-seg patterns are active-low, bit 0 = segment a.
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef enum logic {
    SEL_HI,
    SEL_LO
  } coin_sel_e;

  localparam logic [0:6] SEG0      = 7'b000_0001;
  localparam logic [0:6] SEG1      = 7'b100_1111;
  localparam logic [0:6] SEG2      = 7'b001_0010;
  localparam logic [0:6] SEG3      = 7'b000_0110;
  localparam logic [0:6] SEG4      = 7'b100_1100;
  localparam logic [0:6] SEG5      = 7'b010_0100;
  localparam logic [0:6] SEG6      = 7'b010_0000;
  localparam logic [0:6] SEG7      = 7'b000_1111;
  localparam logic [0:6] SEG8      = 7'b000_0000;
  localparam logic [0:6] SEG9      = 7'b000_0100;
  localparam logic [0:6] SEG_BLANK = 7'b111_1111;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Start/ready/done payout handshake between purchase FSM and dispenser.
// master = requester, slave = dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 5
) ();
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             ready;
  logic             done;
  logic             short_pay;
  logic [AMT_W-1:0] remaining;

  modport master (
    output start, amount,
    input  ready, done, short_pay, remaining
  );

  modport slave (
    input  start, amount,
    output ready, done, short_pay, remaining
  );
endinterface

// File: rtl/change_dispenser_seg7_digit.sv
// One decimal digit to active-low [0:6] 7-seg pattern.
// Codes above 9 blank the digit.
import change_dispenser_pkg::*;

module seg7_digit (
  input  logic [3:0] digit,
  output logic [0:6] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG0;
      4'd1:    seg = SEG1;
      4'd2:    seg = SEG2;
      4'd3:    seg = SEG3;
      4'd4:    seg = SEG4;
      4'd5:    seg = SEG5;
      4'd6:    seg = SEG6;
      4'd7:    seg = SEG7;
      4'd8:    seg = SEG8;
      4'd9:    seg = SEG9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout FSM with timed actuator pulses.
// CHANGE_SEG_EN enables the 7-seg decode of remaining.
import change_dispenser_pkg::*;

module change_dispenser #(
  parameter int AMT_W     = 5,
  parameter int COIN_HI   = 5,
  parameter int COIN_LO   = 1,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   bus,
  input  logic                inhibit,
  output logic                coin_hi,
  output logic                coin_lo,
  output logic [0:6]          hex_ones,
  output logic [0:6]          hex_tens
);
  localparam int CW = cnt_width(PULSE_CYC, GAP_CYC);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);
  localparam logic [AMT_W-1:0] HI_V = AMT_W'(COIN_HI);
  localparam logic [AMT_W-1:0] LO_V = AMT_W'(COIN_LO);

  state_e           state_q, state_d;
  coin_sel_e        sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AMT_W-1:0] bal_q, bal_d;
  logic             shf_q, shf_d;

  logic             ready_q;
  logic             done_q;
  logic             short_q;
  logic [AMT_W-1:0] rem_q;

  logic             accept;
  logic [AMT_W-1:0] src;
  logic [AMT_W-1:0] coin_v;
  state_e           pk_state;
  coin_sel_e        pk_sel;
  logic             pk_short;

  assign accept = bus.start & ready_q & (state_q == ST_IDLE);
  assign coin_v = (sel_q == SEL_HI) ? HI_V : LO_V;

  // Greedy choice of the next step for a given balance
  always_comb begin
    src      = (state_q == ST_IDLE) ? bus.amount : bal_q;
    pk_state = ST_DONE;
    pk_sel   = SEL_LO;
    pk_short = 1'b0;
    unique case (1'b1)
      (src == '0): begin
        pk_state = ST_DONE;
      end
      (src >= HI_V): begin
        pk_state = ST_PULSE;
        pk_sel   = SEL_HI;
      end
      (src >= LO_V && src < HI_V): begin
        pk_state = ST_PULSE;
        pk_sel   = SEL_LO;
      end
      default: begin
        pk_short = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    bal_d   = bal_q;
    shf_d   = shf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bal_d   = bus.amount;
          state_d = pk_state;
          sel_d   = pk_sel;
          shf_d   = pk_short;
          cnt_d   = '0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == P_LAST) begin
          bal_d   = bal_q - coin_v;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        // inhibit parks the counter at terminal
        if (cnt_q != G_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!inhibit) begin
          cnt_d   = '0;
          state_d = pk_state;
          sel_d   = pk_sel;
          shf_d   = pk_short;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_HI;
      cnt_q   <= '0;
      bal_q   <= '0;
      shf_q   <= 1'b0;
      ready_q <= 1'b1;
      coin_hi <= 1'b0;
      coin_lo <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      bal_q   <= bal_d;
      shf_q   <= shf_d;
      ready_q <= (state_q == ST_IDLE) & ~accept;
      coin_hi <= (state_q == ST_PULSE) & (sel_q == SEL_HI);
      coin_lo <= (state_q == ST_PULSE) & (sel_q == SEL_LO);
      done_q  <= (state_q == ST_DONE);
      short_q <= (state_q == ST_DONE) & shf_q;
      rem_q   <= bal_q;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.short_pay = short_q;
  assign bus.remaining = rem_q;

`ifdef CHANGE_SEG_EN
  logic [31:0] rv;
  logic [3:0]  d_ones;
  logic [3:0]  d_tens;

  always_comb begin
    rv     = 32'(rem_q);
    d_ones = 4'hF;
    d_tens = 4'hF;
    if (rv < 32'd100) begin
      d_ones = 4'(rv % 32'd10);
      d_tens = 4'(rv / 32'd10);
    end
  end

  seg7_digit u_ones (
    .digit (d_ones),
    .seg   (hex_ones)
  );

  seg7_digit u_tens (
    .digit (d_tens),
    .seg   (hex_tens)
  );
`else
  assign hex_ones = SEG_BLANK;
  assign hex_tens = SEG_BLANK;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser against a greedy payout model.
// Honours CHANGE_SEG_EN for the 7-seg expectations.
module tb_change_dispenser;
  localparam int HI = 5;
  localparam int LO = 1;
  localparam int P  = 4;
  localparam int G  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inhibit = 1'b0;
  logic inhibit2 = 1'b0;
  logic coin_hi, coin_lo, coin_hi2, coin_lo2;
  logic [0:6] hex_ones, hex_tens, hex_ones2, hex_tens2;

  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(5)) b ();
  change_dispenser_if #(.AMT_W(5)) b2 ();

  change_dispenser dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (b),
    .inhibit  (inhibit),
    .coin_hi  (coin_hi),
    .coin_lo  (coin_lo),
    .hex_ones (hex_ones),
    .hex_tens (hex_tens)
  );

  change_dispenser #(.COIN_LO(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .bus      (b2),
    .inhibit  (inhibit2),
    .coin_hi  (coin_hi2),
    .coin_lo  (coin_lo2),
    .hex_ones (hex_ones2),
    .hex_tens (hex_tens2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit inh [0:511];

  int hi_cnt, lo_cnt, width_bad, both_bad, order_bad, min_gap, done_cyc;
  bit timeout;
  logic fin_short, fin_ready;
  logic [4:0] fin_rem;
  int hi_starts[$];
  int lo_starts[$];
  int rlog[$];
  logic [0:6] ones_log[$];
  logic [0:6] tens_log[$];

  function automatic logic [0:6] seg_exp(input int v);
    logic [0:6] t [10];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100};
`ifdef CHANGE_SEG_EN
    return t[v];
`else
    return 7'b1111111;
`endif
  endfunction

  function automatic logic [0:6] ones_exp(input int v);
    if (v >= 100) return 7'b1111111;
    return seg_exp(v % 10);
  endfunction

  function automatic logic [0:6] tens_exp(input int v);
    if (v >= 100) return 7'b1111111;
    return seg_exp((v / 10) % 10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inh();
    for (int i = 0; i < 512; i++) inh[i] = 1'b0;
  endtask

  // Drives one payout and records what the outputs did, no judging here
  task automatic run_txn(input int amt, input int xcyc, input int xamt,
                         input int budget);
    int run_h, run_l, gap, w;
    bit seen_lo, seen_p;
    hi_cnt = 0; lo_cnt = 0; width_bad = 0; both_bad = 0;
    order_bad = 0; min_gap = 1000; done_cyc = -1; timeout = 1'b0;
    fin_short = 1'b0; fin_ready = 1'b0; fin_rem = '0;
    hi_starts.delete(); lo_starts.delete(); rlog.delete();
    ones_log.delete(); tens_log.delete();
    w = 0;
    while (b.ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    if (b.ready !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    b.start = 1'b1;
    b.amount = 5'(amt);
    inhibit = inh[0];
    step();
    b.start = 1'b0;
    run_h = 0; run_l = 0; gap = 0; seen_lo = 0; seen_p = 0;
    for (int c = 1; c <= budget; c++) begin
      inhibit = inh[c];
      if (c == xcyc) begin
        b.start = 1'b1;
        b.amount = 5'(xamt);
      end
      step();
      b.start = 1'b0;
      if (coin_hi && coin_lo) both_bad++;
      if (coin_hi) begin
        if (run_h == 0) begin
          hi_starts.push_back(c);
          if (seen_lo) order_bad++;
          if (seen_p && gap < min_gap) min_gap = gap;
        end
        run_h++;
      end else if (run_h > 0) begin
        if (run_h != P) width_bad++;
        hi_cnt++;
        run_h = 0;
      end
      if (coin_lo) begin
        if (run_l == 0) begin
          lo_starts.push_back(c);
          seen_lo = 1;
          if (seen_p && gap < min_gap) min_gap = gap;
        end
        run_l++;
      end else if (run_l > 0) begin
        if (run_l != P) width_bad++;
        lo_cnt++;
        run_l = 0;
      end
      if (!coin_hi && !coin_lo) gap++;
      else begin
        gap = 0;
        seen_p = 1;
      end
      rlog.push_back(int'(b.remaining));
      ones_log.push_back(hex_ones);
      tens_log.push_back(hex_tens);
      if (b.done === 1'b1) begin
        done_cyc = c;
        fin_short = b.short_pay;
        fin_rem = b.remaining;
        fin_ready = b.ready;
        break;
      end
    end
    inhibit = 1'b0;
    if (done_cyc < 0) timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (b.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got=%b want=1", b.ready);
    end
    n_cmp++;
    if ({coin_hi, coin_lo, b.done, b.short_pay} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outs got=%b%b%b%b want=0000",
               coin_hi, coin_lo, b.done, b.short_pay);
    end
    n_cmp++;
    if (b.remaining !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_remaining got=%0d want=0", b.remaining);
    end
    n_cmp++;
    if (hex_ones !== ones_exp(0) || hex_tens !== tens_exp(0)) begin
      n_bad++;
      $display("FAIL reset_hex got=%b/%b want=%b/%b",
               hex_tens, hex_ones, tens_exp(0), ones_exp(0));
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_amount7();
    int tr[$];
    clear_inh();
    run_txn(7, -1, 0, 100);
    n_cmp++;
    if (timeout || done_cyc != 19) begin
      n_bad++;
      $display("FAIL a7_done_cycle got=%0d want=19", done_cyc);
    end
    n_cmp++;
    if (hi_starts.size() != 1 || hi_starts[0] != 1) begin
      n_bad++;
      $display("FAIL a7_hi_start got_n=%0d want_n=1 at 1", hi_starts.size());
    end
    n_cmp++;
    if (lo_starts.size() != 2 || lo_starts[0] != 7 || lo_starts[1] != 13) begin
      n_bad++;
      $display("FAIL a7_lo_starts got_n=%0d want=7,13", lo_starts.size());
    end
    n_cmp++;
    if (width_bad != 0 || both_bad != 0) begin
      n_bad++;
      $display("FAIL a7_pulse_shape got width_bad=%0d both=%0d want 0/0",
               width_bad, both_bad);
    end
    foreach (rlog[i])
      if (tr.size() == 0 || tr[tr.size()-1] != rlog[i]) tr.push_back(rlog[i]);
    n_cmp++;
    if (tr.size() != 4 || tr[0] != 7 || tr[1] != 2 || tr[2] != 1 || tr[3] != 0) begin
      n_bad++;
      $display("FAIL a7_remaining_trace got_n=%0d want=7,2,1,0", tr.size());
    end
    n_cmp++;
    if (fin_short !== 1'b0 || fin_rem !== 5'd0) begin
      n_bad++;
      $display("FAIL a7_final got short=%b rem=%0d want 0/0", fin_short, fin_rem);
    end
    step();
    n_cmp++;
    if (b.done !== 1'b0) begin
      n_bad++;
      $display("FAIL a7_done_width got=%b want=0", b.done);
    end
  endtask

  task automatic test_zero();
    clear_inh();
    run_txn(0, -1, 0, 20);
    n_cmp++;
    if (timeout || done_cyc != 1 || hi_cnt + lo_cnt != 0) begin
      n_bad++;
      $display("FAIL zero_done got cyc=%0d coins=%0d want 1/0",
               done_cyc, hi_cnt + lo_cnt);
    end
    n_cmp++;
    if (fin_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_ready_c1 got=%b want=0", fin_ready);
    end
    step();
    n_cmp++;
    if (b.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_ready_c2 got=%b want=1", b.ready);
    end
  endtask

  task automatic test_inhibit();
    clear_inh();
    for (int i = 5; i <= 9; i++) inh[i] = 1'b1;
    run_txn(5, -1, 0, 60);
    clear_inh();
    n_cmp++;
    if (timeout || done_cyc != 11) begin
      n_bad++;
      $display("FAIL inhibit_done got=%0d want=11", done_cyc);
    end
    n_cmp++;
    if (hi_cnt != 1 || lo_cnt != 0 || width_bad != 0) begin
      n_bad++;
      $display("FAIL inhibit_pulse got hi=%0d lo=%0d wbad=%0d want 1/0/0",
               hi_cnt, lo_cnt, width_bad);
    end
  endtask

  task automatic test_ignored_start();
    clear_inh();
    run_txn(6, 3, 9, 60);
    n_cmp++;
    if (timeout || done_cyc != 13) begin
      n_bad++;
      $display("FAIL ignored_start_done got=%0d want=13", done_cyc);
    end
    n_cmp++;
    if (hi_cnt != 1 || lo_cnt != 1 || fin_rem !== 5'd0) begin
      n_bad++;
      $display("FAIL ignored_start_pay got hi=%0d lo=%0d rem=%0d want 1/1/0",
               hi_cnt, lo_cnt, fin_rem);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    int w;
    w = 0;
    while (b.ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    b.start = 1'b1;
    b.amount = 5'd9;
    step();
    b.start = 1'b0;
    step();
    step();
    n_cmp++;
    if (coin_hi !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_pre got coin_hi=%b want=1", coin_hi);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (coin_hi !== 1'b0 || b.remaining !== 5'd0 || b.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_state got hi=%b rem=%0d rdy=%b want 0/0/1",
               coin_hi, b.remaining, b.ready);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b.done !== 1'b0 || coin_hi !== 1'b0 || coin_lo !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL midreset_quiet got=%0d active cycles want=0", bad);
    end
  endtask

  task automatic test_seg();
    int tr[$];
    int v;
    int hb;
    clear_inh();
    run_txn(12, -1, 0, 120);
    foreach (rlog[i])
      if (tr.size() == 0 || tr[tr.size()-1] != rlog[i]) tr.push_back(rlog[i]);
    v = 12;
    n_cmp++;
    if (tr.size() != 5 || tr[0] != 12 || tr[4] != 0) begin
      n_bad++;
      $display("FAIL seg_trace got_n=%0d want=5 (12..0)", tr.size());
    end
    n_cmp++;
    if (ones_log.size() == 0 || ones_log[0] !== ones_exp(12) ||
        tens_log[0] !== tens_exp(12)) begin
      n_bad++;
      $display("FAIL seg_first got=%b/%b want=%b/%b",
               tens_log[0], ones_log[0], tens_exp(12), ones_exp(12));
    end
    hb = 0;
    foreach (rlog[i]) begin
      if (ones_log[i] !== ones_exp(rlog[i]) || tens_log[i] !== tens_exp(rlog[i]))
        hb++;
    end
    n_cmp++;
    if (hb != 0) begin
      n_bad++;
      $display("FAIL seg_decode got=%0d bad cycles want=0", hb);
    end
    // greedy descent of 12 must visit 7 and 2 on the way down
    v = v - HI;
    n_cmp++;
    if (tr.size() < 3 || tr[1] != v || tr[2] != v - HI) begin
      n_bad++;
      $display("FAIL seg_steps got=%0d,%0d want=%0d,%0d",
               (tr.size() > 1) ? tr[1] : -1, (tr.size() > 2) ? tr[2] : -1,
               v, v - HI);
    end
  endtask

  task automatic test_param_lo2();
    int dc;
    int nh;
    int nl;
    int rh;
    dc = -1; nh = 0; nl = 0; rh = 0;
    b2.start = 1'b1;
    b2.amount = 5'd6;
    step();
    b2.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (coin_hi2 && rh == 0) nh++;
      rh = coin_hi2 ? 1 : 0;
      if (coin_lo2) nl++;
      if (b2.done === 1'b1) begin
        dc = c;
        break;
      end
    end
    n_cmp++;
    if (dc != 7 || nh != 1 || nl != 0) begin
      n_bad++;
      $display("FAIL lo2_flow got done=%0d hi=%0d lo_cyc=%0d want 7/1/0",
               dc, nh, nl);
    end
    n_cmp++;
    if (b2.short_pay !== 1'b1 || b2.remaining !== 5'd1) begin
      n_bad++;
      $display("FAIL lo2_short got sp=%b rem=%0d want 1/1",
               b2.short_pay, b2.remaining);
    end
  endtask

  task automatic test_random();
    int amt, xc, nh, nl, res, lat;
    bit use_inh;
    for (int t = 0; t < 30; t++) begin
      amt = $urandom_range(0, 31);
      use_inh = ($urandom_range(0, 2) == 0);
      clear_inh();
      if (use_inh)
        for (int i = 0; i < 512; i++) inh[i] = ($urandom_range(0, 9) < 3);
      xc = -1;
      if (amt >= LO && $urandom_range(0, 2) == 0) xc = $urandom_range(1, 5);
      run_txn(amt, xc, $urandom_range(0, 31), 450);
      clear_inh();
      nh = amt / HI;
      nl = (amt % HI) / LO;
      res = (amt % HI) % LO;
      lat = (nh + nl) * (P + G) + 1;
      n_cmp++;
      if (timeout || hi_cnt != nh || lo_cnt != nl) begin
        n_bad++;
        $display("FAIL rnd_coins amt=%0d got hi=%0d lo=%0d to=%0b want %0d/%0d",
                 amt, hi_cnt, lo_cnt, timeout, nh, nl);
      end
      n_cmp++;
      if (width_bad != 0 || both_bad != 0 || order_bad != 0 ||
          (hi_cnt + lo_cnt > 1 && min_gap < G)) begin
        n_bad++;
        $display("FAIL rnd_shape amt=%0d got w=%0d b=%0d o=%0d gap=%0d",
                 amt, width_bad, both_bad, order_bad, min_gap);
      end
      n_cmp++;
      if (int'(fin_rem) != res || fin_short !== (res != 0)) begin
        n_bad++;
        $display("FAIL rnd_final amt=%0d got rem=%0d sp=%b want rem=%0d",
                 amt, fin_rem, fin_short, res);
      end
      n_cmp++;
      if ((!use_inh && done_cyc != lat) || (use_inh && done_cyc < lat)) begin
        n_bad++;
        $display("FAIL rnd_latency amt=%0d inh=%0b got=%0d want=%0d",
                 amt, use_inh, done_cyc, lat);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    b.start = 1'b0;
    b.amount = '0;
    b2.start = 1'b0;
    b2.amount = '0;
    clear_inh();
    test_reset();
    test_amount7();
    test_zero();
    test_inhibit();
    test_ignored_start();
    test_reset_mid();
    test_seg();
    test_param_lo2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
